// File: rtl/dense_logit_argmax_reader.sv
// Reader side of the dense layer result port: kicks the layer, waits for done, sweeps the logits and keeps the signed argmax.
// Optional WAIT_DONE watchdog is compiled in with `define ARGMAX_TIMEOUT_EN.
module dense_logit_argmax_reader #(
    parameter int NUM_CLASSES    = 10,
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int READ_LAT       = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              layer_start,
    input  logic              layer_done,
    output logic [ADDR_W-1:0] layer_read_addr,
    input  logic [DATA_W-1:0] layer_read_data,
    output logic              busy,
    output logic              result_valid,
    output logic [ADDR_W-1:0] class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              timeout_err
);

    typedef enum logic [2:0] {IDLE, KICK, WAIT_DONE, READ, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

    state_t            state_reg;
    logic [DATA_W-1:0] max_val_reg;
    logic [ADDR_W-1:0] max_idx_reg;
    logic              issue_vld;
    logic              sample_vld;
    logic [ADDR_W-1:0] sample_idx;

    assign issue_vld = (state_reg == READ);

    // Address tags travel alongside the memory latency so each sample knows its class index.
    generate
        if (READ_LAT == 0) begin : g_direct
            assign sample_vld = issue_vld;
            assign sample_idx = layer_read_addr;
        end else begin : g_pipe
            localparam int PW = READ_LAT * ADDR_W;
            logic [READ_LAT-1:0] vld_pipe_reg;
            logic [PW-1:0]       idx_pipe_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_pipe_reg <= '0;
                    idx_pipe_reg <= '0;
                end else begin
                    vld_pipe_reg <= (vld_pipe_reg << 1) | READ_LAT'(issue_vld);
                    idx_pipe_reg <= (idx_pipe_reg << ADDR_W) | PW'(layer_read_addr);
                end
            end

            assign sample_vld = vld_pipe_reg[READ_LAT-1];
            assign sample_idx = idx_pipe_reg[PW-1 -: ADDR_W];
        end
    endgenerate

`ifdef ARGMAX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_reg;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            layer_start     <= 1'b0;
            layer_read_addr <= '0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            class_idx       <= '0;
            class_score     <= '0;
            max_val_reg     <= '0;
            max_idx_reg     <= '0;
`ifdef ARGMAX_TIMEOUT_EN
            wd_cnt_reg      <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            layer_start <= 1'b0;

            // Index 0 seeds the maximum; strict compare keeps the lowest index on ties.
            if (sample_vld) begin
                if (sample_idx == '0 || $signed(layer_read_data) > $signed(max_val_reg)) begin
                    max_val_reg <= layer_read_data;
                    max_idx_reg <= sample_idx;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        layer_start  <= 1'b1;
`ifdef ARGMAX_TIMEOUT_EN
                        timeout_err  <= 1'b0;
`endif
                        state_reg    <= KICK;
                    end
                end
                KICK: begin
`ifdef ARGMAX_TIMEOUT_EN
                    wd_cnt_reg <= '0;
`endif
                    state_reg <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (layer_done) begin
                        layer_read_addr <= '0;
                        state_reg       <= READ;
                    end
`ifdef ARGMAX_TIMEOUT_EN
                    else if (wd_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + TW'(1);
                    end
`endif
                end
                READ: begin
                    if (layer_read_addr == LAST_ADDR) begin
                        state_reg <= (READ_LAT == 0) ? FINISH : DRAIN;
                    end else begin
                        layer_read_addr <= layer_read_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (sample_vld && sample_idx == LAST_ADDR) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    class_idx    <= max_idx_reg;
                    class_score  <= max_val_reg;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_logit_argmax_reader.sv
// Bench for dense_logit_argmax_reader: READ_LAT=0 and READ_LAT=2 instances, scoreboard of expected argmax results.
module tb_dense_logit_argmax_reader;

    localparam int N = 10;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] score;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, start2, done0, done2;
    logic        ls0, ls2, busy0, busy2, rv0, rv2, te0, te2;
    logic [3:0]  addr0, addr2, idx0, idx2;
    logic [31:0] rd0, rd2, score0, score2;

    logic [31:0] mem0 [N];
    logic [31:0] mem2 [N];
    logic [31:0] r1, r2;
    int          lg [N];

    exp_t sbq [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   lsc0 = 0;
    int   lsc2 = 0;

    assign rd0 = mem0[addr0];
    // Two-stage registered memory model for the READ_LAT=2 instance.
    always @(posedge clk) begin
        r1 <= mem2[addr2];
        r2 <= r1;
    end
    assign rd2 = r2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ls0) lsc0 <= lsc0 + 1;
        if (ls2) lsc2 <= lsc2 + 1;
    end

    dense_logit_argmax_reader #(
        .NUM_CLASSES(N), .ADDR_W(4), .DATA_W(32), .READ_LAT(0), .TIMEOUT_CYCLES(20)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .layer_start(ls0), .layer_done(done0),
        .layer_read_addr(addr0), .layer_read_data(rd0), .busy(busy0), .result_valid(rv0),
        .class_idx(idx0), .class_score(score0), .timeout_err(te0)
    );

    dense_logit_argmax_reader #(
        .NUM_CLASSES(N), .ADDR_W(4), .DATA_W(32), .READ_LAT(2), .TIMEOUT_CYCLES(20)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .layer_start(ls2), .layer_done(done2),
        .layer_read_addr(addr2), .layer_read_data(rd2), .busy(busy2), .result_valid(rv2),
        .class_idx(idx2), .class_score(score2), .timeout_err(te2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start2 = v; else start0 = v;
    endtask

    task automatic set_done(input bit sel, input logic v);
        if (sel) done2 = v; else done0 = v;
    endtask

    // One classification run; pre=1 means layer_done is already high before the kick.
    task automatic run(input bit sel, input int exp_i, input int exp_s, input bit pre,
                       input bit extra, input string tag);
        int   c, e0, lat, lsb;
        bit   got, pb;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (sel) mem2[i] = lg[i]; else mem0[i] = lg[i];
        end
        lat = sel ? 2 : 0;
        e.idx   = 4'(exp_i);
        e.score = 32'(exp_s);
        sbq.push_back(e);
        lsb = sel ? lsc2 : lsc0;
        if (!pre) set_done(sel, 1'b0);
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        check({tag, " busy"}, 64'(sel ? busy2 : busy0), 64'd1);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (sel ? ls2 : ls0) begin got = 1; break; end
            @(negedge clk);
        end
        check({tag, " kick seen"}, 64'(got), 64'd1);
        c = cyc;
        if (pre) begin
            e0 = c + 2;
        end else begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                set_start(sel, extra && k == 0);
            end
            set_start(sel, 1'b0);
            set_done(sel, 1'b1);
            e0 = cyc + 1;
        end
        got = 0;
        pb  = sel ? busy2 : busy0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sel ? rv2 : rv0) begin got = 1; break; end
            pb = sel ? busy2 : busy0;
        end
        check({tag, " result seen"}, 64'(got), 64'd1);
        check({tag, " latency edge"}, 64'(cyc), 64'(e0 + N + lat + 1));
        check({tag, " busy fall"}, 64'({pb, sel ? busy2 : busy0}), 64'b10);
        e = sbq.pop_front();
        check({tag, " class_idx"}, 64'(sel ? idx2 : idx0), 64'(e.idx));
        check({tag, " class_score"}, 64'(sel ? score2 : score0), 64'(e.score));
        check({tag, " kick count"}, 64'((sel ? lsc2 : lsc0) - lsb), 64'd1);
        @(negedge clk); @(negedge clk);
        check({tag, " result hold"}, 64'({sel ? rv2 : rv0, sel ? idx2 : idx0}), 64'({1'b1, e.idx}));
        set_done(sel, 1'b0);
        $display("run %s: idx=%0d score=%0d", tag, sel ? idx2 : idx0,
                 $signed(sel ? score2 : score0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  c;
        bit  got;
        reset = 1'b1; start0 = 0; start2 = 0; done0 = 0; done2 = 0;
        for (int i = 0; i < N; i++) begin mem0[i] = '0; mem2[i] = '0; end
        @(negedge clk); @(negedge clk);
        check("reset state dut0", {ls0, addr0, busy0, rv0, idx0, score0, te0}, 64'd0);
        check("reset state dut2", {ls2, addr2, busy2, rv2, idx2, score2, te2}, 64'd0);
        reset = 1'b0;

        lg = '{5, -3, 12, 0, 7, 100, -100, 101, 2, 9};
        run(0, 7, 101, 0, 0, "basic lat0");
        lg = '{10, 20, 50, -5, 49, 50, 0, 1, 2, 3};
        run(0, 2, 50, 0, 0, "tie lat0");
        lg = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
        run(0, 9, -1, 0, 0, "all negative lat0");
        lg = '{32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run(0, 0, 32'h7FFFFFFF, 0, 0, "first max lat0");

        lg = '{5, -3, 12, 0, 7, 100, -100, 101, 2, 9};
        run(1, 7, 101, 0, 1, "basic lat2 with restart");
        lg = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
        run(1, 9, -1, 0, 0, "all negative lat2");

        // Abort mid-sweep with reset, then rerun with layer_done still high.
        lg = '{5, -3, 12, 0, 7, 100, -100, 101, 2, 9};
        for (int i = 0; i < N; i++) mem0[i] = lg[i];
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk); @(negedge clk);
        done0 = 1'b1;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (addr0 == 4'd4 && busy0) begin got = 1; break; end
        end
        check("reach addr 4", 64'(got), 64'd1);
        reset = 1'b1;
        #1;
        check("mid-read reset outputs", {ls0, addr0, busy0, rv0, idx0, score0, te0}, 64'd0);
        @(negedge clk); reset = 1'b0;
        run(0, 7, 101, 1, 0, "done already high");

        // Watchdog run: layer_done held low.
        done0 = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        c = cyc;
        while (cyc < c + 20) @(negedge clk);
        check("timeout not yet", 64'({te0, busy0}), 64'b01);
        @(negedge clk);
`ifdef ARGMAX_TIMEOUT_EN
        check("timeout fired", 64'({te0, busy0, rv0}), 64'b100);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        check("timeout cleared by start", 64'({te0, busy0}), 64'b01);
`else
        check("no watchdog", 64'({te0, busy0, rv0}), 64'b010);
`endif
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dense_logit_argmax_reader.md
Name: dense_logit_argmax_reader

Overview:
- Downstream consumer of the final dense layer's start/done and read_addr/read_data result interface. It is the reader side of that interface.
- On request it:
  - kicks the layer;
  - waits for layer completion;
  - sweeps the layer's output buffer;
  - computes the signed argmax over the logits.
- It exposes the winning class index and score to the SoC classification/readout logic.

Parameters:
- NUM_CLASSES, 10, number of logits to read (addresses 0..NUM_CLASSES-1).
- ADDR_W, 4, width of layer_read_addr and class_idx.
- DATA_W, 32, logit width; logits are signed two's complement.
- READ_LAT, 0, cycles from address presentation to valid layer_read_data. Legal values are 0, 1, 2.
- TIMEOUT_CYCLES, 1000000, WAIT_DONE watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run a classification.
- layer_start  out  1  single-cycle start pulse to the dense layer.
- layer_done  in  1  dense layer done. Level: may stay high indefinitely.
- layer_read_addr  out  ADDR_W  logit address to the dense layer.
- layer_read_data  in  DATA_W  logit data, valid READ_LAT cycles after its address.
- busy  out  1  high from start acceptance until result_valid or error.
- result_valid  out  1  level; high when class_idx/class_score are valid.
- class_idx  out  ADDR_W  index of the maximum logit.
- class_score  out  DATA_W  value of the maximum logit.
- timeout_err  out  1  watchdog flag. Tied 0 when the feature is absent.

Behaviour:
- Reset (asynchronous, any state, including mid-sweep): state=IDLE. All outputs are 0: layer_start, layer_read_addr, busy, result_valid, class_idx, class_score, timeout_err. Internal read pipeline and max registers are cleared.
- IDLE:
  - start=1 is accepted. On that edge: busy<=1, result_valid<=0, timeout_err<=0, state<=KICK.
  - start while busy is ignored.
- KICK (1 cycle): layer_start=1 for exactly this cycle, then state<=WAIT_DONE.
- WAIT_DONE:
  - Samples layer_done from the cycle after KICK onward.
  - layer_done is level-sensitive. If it is still high from a previous run, it is accepted on the first WAIT_DONE cycle.
  - On sampled 1: layer_read_addr<=0, state<=READ.
- READ:
  - layer_read_addr increments by 1 per cycle through NUM_CLASSES-1.
  - The issued address is carried through a READ_LAT-deep shift register with a valid bit.
  - Data is captured when the matching valid emerges. With READ_LAT=0, data is captured in the same cycle the address is driven.
  - After issuing the last address, state<=DRAIN. With READ_LAT=0, DRAIN is skipped and the block goes straight to FINISH.
- DRAIN: waits until all READ_LAT pending samples are consumed, then state<=FINISH.
- Compare rule:
  - The first sample (index 0) unconditionally loads max_val/max_idx.
  - Later samples replace the maximum only if strictly greater, using a signed DATA_W compare.
  - Ties therefore keep the lowest index.
- FINISH (1 cycle): class_idx<=max_idx, class_score<=max_val, result_valid<=1, busy<=0, state<=IDLE.
- Outputs hold until the next accepted start or reset.
- Latency: call the edge where WAIT_DONE samples layer_done=1 E0. result_valid is high after edge E0+NUM_CLASSES+READ_LAT+1. Default configuration: E0+11.
- layer_read_addr holds its last value outside READ.
- start coincident with FINISH is ignored, since busy is still 1.

Optional Feature:
- Macro: ARGMAX_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE and is cleared on WAIT_DONE entry.
  - If it reaches TIMEOUT_CYCLES without layer_done, then timeout_err<=1, busy<=0, result_valid stays 0, state<=IDLE.
  - timeout_err stays high until the next accepted start or reset.
- Undefined: no counter; WAIT_DONE waits forever; timeout_err is tied 0.

Test Plan:
- Logits {5,-3,12,0,7,100,-100,101,2,9}, READ_LAT=0, start pulse. Required: exactly one layer_start pulse; class_idx=7 and class_score=101 at E0+11; busy falls on the same edge.
- Tie case: logits with value 50 at indices 2 and 5, all others less than 50. Required: class_idx=2, class_score=50.
- All-negative logits {-10,-9,...,-1}. Required: class_idx=9, class_score=-1. Also, first-element-max {32'h7FFFFFFF, rest 0}. Required: class_idx=0.
- READ_LAT=2 with a registered-memory model. Required: same results as READ_LAT=0; result_valid at E0+13; second start pulse while busy produces no second layer_start.
- Reset asserted mid-READ at address 4. Required: all outputs 0 immediately. Then a new start with layer_done already high gives a correct result; WAIT_DONE lasts 1 cycle.
- With ARGMAX_TIMEOUT_EN and TIMEOUT_CYCLES=20, layer_done held 0. Required: timeout_err=1 and busy=0 after 20 WAIT_DONE cycles; result_valid=0. Next start clears timeout_err.
